// File: rtl/cnet_prog_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cnet_prog_ctrl
//
// SelectMAP programming controller for the CNET FPGA. It takes bitstream
// bytes from the host reprogramming FIFO and drives the CNET configuration
// pins in this order:
//   1. PROG_B pulse.
//   2. Wait for INIT_B to go high.
//   3. Byte writes, using CS_B/DATA with RDWR_B held low.
//   4. Wait for DONE.
// It then reports success (done pulse) or a categorized error (err_code).
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle request; honored only in IDLE
//   prog_data[7:0]        bitstream byte from the FIFO
//   prog_data_vld         prog_data valid
//   prog_last             marks the final byte (qualified by vld & rdy)
//   prog_data_rdy         controller can take a byte this cycle
//   busy                  any state other than IDLE
//   done                  one-cycle pulse on successful completion
//   error, err_code[1:0]  sticky error flag and cause
//                         (1 init timeout, 2 CRC, 3 done timeout)
//   byte_cnt[23:0]        bytes accepted since the last start (saturating)
//   rp_cclk               configuration clock, free-running clk/2
//   rp_prog_b, rp_cs_b, rp_rdwr_b, rp_data[7:0]
//                         configuration pins, all registered
//   rp_init_b, rp_done    CNET status pins, asynchronous, double-flopped here
//
// Handshake: a byte transfers on a clk edge where prog_data_vld and
// prog_data_rdy are both high. The source may raise vld at any time and must
// hold prog_data/prog_last stable while vld is high and rdy is low. rdy does
// not depend on vld.
// -----------------------------------------------------------------------------
module cnet_prog_ctrl #(
    parameter int PROG_B_CYCLES = 32,
    parameter int INIT_TIMEOUT  = 4096,
    parameter int DONE_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prog_data,
    input  logic        prog_data_vld,
    input  logic        prog_last,
    output logic        prog_data_rdy,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [23:0] byte_cnt,
    output logic        rp_cclk,
    output logic        rp_prog_b,
    output logic        rp_cs_b,
    output logic        rp_rdwr_b,
    output logic [7:0]  rp_data,
    input  logic        rp_init_b,
    input  logic        rp_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PULSE     = 3'd1,
        S_WAIT_INIT = 3'd2,
        S_LOAD      = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [1:0] ERR_INIT = 2'd1;
    localparam logic [1:0] ERR_CRC  = 2'd2;
    localparam logic [1:0] ERR_DONE = 2'd3;

    // Counters are loaded with N-1 so that a state lasts exactly N cycles,
    // with the exit or timeout taken on the cycle the counter reads 0.
    localparam logic [31:0] PROG_LOAD = 32'(PROG_B_CYCLES - 1);
    localparam logic [31:0] INIT_LOAD = 32'(INIT_TIMEOUT - 1);
    localparam logic [31:0] DONE_LOAD = 32'(DONE_TIMEOUT - 1);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic        cclk_q;
    logic        prog_b_q, prog_b_n;
    logic        cs_b_q, cs_b_n;
    logic        rdwr_b_q, rdwr_b_n;
    logic [7:0]  data_q, data_n;
    logic [23:0] byte_cnt_q, byte_cnt_n;
    logic        error_q, error_n;
    logic [1:0]  err_code_q, err_code_n;
    logic        done_q, done_n;
    logic        init_s1, init_s;
    logic        done_s1, done_s;
    logic        ph;
    logic        rdy;
    logic        accept;
    logic        go_idle;

    // ph is the current rp_cclk level. Pin updates made on a ph=1 edge land on
    // the falling edge of rp_cclk, so they are stable across the next rise.
    assign ph     = cclk_q;
    assign rdy    = (state == S_LOAD) && ph && init_s;
    assign accept = prog_data_vld && rdy;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        prog_b_n   = prog_b_q;
        cs_b_n     = cs_b_q;
        rdwr_b_n   = rdwr_b_q;
        data_n     = data_q;
        byte_cnt_n = byte_cnt_q;
        error_n    = error_q;
        err_code_n = err_code_q;
        done_n     = 1'b0;
        go_idle    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    error_n    = 1'b0;
                    err_code_n = 2'd0;
                    byte_cnt_n = 24'd0;
                    prog_b_n   = 1'b0;
                    rdwr_b_n   = 1'b0;
                    cnt_n      = PROG_LOAD;
                    state_n    = S_PULSE;
                end
            end

            S_PULSE: begin
                if (cnt == 32'd0) begin
                    prog_b_n = 1'b1;
                    cnt_n    = INIT_LOAD;
                    state_n  = S_WAIT_INIT;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end

            S_WAIT_INIT: begin
                // The awaited condition is tested first so it beats a timeout
                // that would expire on the same cycle.
                if (init_s) begin
                    state_n = S_LOAD;
                end else if (cnt == 32'd0) begin
                    error_n    = 1'b1;
                    err_code_n = ERR_INIT;
                    go_idle    = 1'b1;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end

            S_LOAD: begin
                // rdy is gated by init_s, so a CRC error can never coincide
                // with an accepted byte (including the last one).
                if (!init_s) begin
                    error_n    = 1'b1;
                    err_code_n = ERR_CRC;
                    go_idle    = 1'b1;
                end else if (accept) begin
                    data_n     = prog_data;
                    cs_b_n     = 1'b0;
                    byte_cnt_n = (byte_cnt_q == 24'hFF_FFFF) ? byte_cnt_q
                                                             : byte_cnt_q + 24'd1;
                    if (prog_last) begin
                        cnt_n   = DONE_LOAD;
                        state_n = S_WAIT_DONE;
                    end
                end else if (ph) begin
                    cs_b_n = 1'b1;
                end
            end

            S_WAIT_DONE: begin
                // The last byte's chip select is released on the next falling
                // edge of rp_cclk, as in LOAD.
                if (ph) begin
                    cs_b_n = 1'b1;
                end
                if (!init_s) begin
                    error_n    = 1'b1;
                    err_code_n = ERR_CRC;
                    go_idle    = 1'b1;
                end else if (done_s) begin
                    done_n  = 1'b1;
                    go_idle = 1'b1;
                end else if (cnt == 32'd0) begin
                    error_n    = 1'b1;
                    err_code_n = ERR_DONE;
                    go_idle    = 1'b1;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        // Every path back to IDLE parks the configuration pins. A CRC error
        // releases chip select here without waiting for the rp_cclk phase.
        if (go_idle) begin
            state_n  = S_IDLE;
            prog_b_n = 1'b1;
            cs_b_n   = 1'b1;
            rdwr_b_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 32'd0;
            cclk_q     <= 1'b0;
            prog_b_q   <= 1'b1;
            cs_b_q     <= 1'b1;
            rdwr_b_q   <= 1'b1;
            data_q     <= 8'd0;
            byte_cnt_q <= 24'd0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            done_q     <= 1'b0;
            init_s1    <= 1'b0;
            init_s     <= 1'b0;
            done_s1    <= 1'b0;
            done_s     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cclk_q     <= ~cclk_q;
            prog_b_q   <= prog_b_n;
            cs_b_q     <= cs_b_n;
            rdwr_b_q   <= rdwr_b_n;
            data_q     <= data_n;
            byte_cnt_q <= byte_cnt_n;
            error_q    <= error_n;
            err_code_q <= err_code_n;
            done_q     <= done_n;
            init_s1    <= rp_init_b;
            init_s     <= init_s1;
            done_s1    <= rp_done;
            done_s     <= done_s1;
        end
    end

    assign prog_data_rdy = rdy;
    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign byte_cnt      = byte_cnt_q;
    assign rp_cclk       = cclk_q;
    assign rp_prog_b     = prog_b_q;
    assign rp_cs_b       = cs_b_q;
    assign rp_rdwr_b     = rdwr_b_q;
    assign rp_data       = data_q;

endmodule

// File: tb/tb_cnet_prog_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cnet_prog_ctrl. A small CNET model answers the
// configuration pins, and captured bytes are scored against an expected queue.
module tb_cnet_prog_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        start = 1'b0;
    logic [7:0]  prog_data = 8'd0;
    logic        prog_data_vld = 1'b0;
    logic        prog_last = 1'b0;
    logic        prog_data_rdy;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [23:0] byte_cnt;
    logic        rp_cclk;
    logic        rp_prog_b;
    logic        rp_cs_b;
    logic        rp_rdwr_b;
    logic [7:0]  rp_data;
    logic        rp_init_b = 1'b1;
    logic        rp_done = 1'b0;

    cnet_prog_ctrl #(
        .PROG_B_CYCLES(32),
        .INIT_TIMEOUT (4096),
        .DONE_TIMEOUT (1024)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_data    (prog_data),
        .prog_data_vld(prog_data_vld),
        .prog_last    (prog_last),
        .prog_data_rdy(prog_data_rdy),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .byte_cnt     (byte_cnt),
        .rp_cclk      (rp_cclk),
        .rp_prog_b    (rp_prog_b),
        .rp_cs_b      (rp_cs_b),
        .rp_rdwr_b    (rp_rdwr_b),
        .rp_data      (rp_data),
        .rp_init_b    (rp_init_b),
        .rp_done      (rp_done)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- CNET model ----------------
    // All sampling happens on the falling clk edge. A rising rp_cclk edge
    // occurred between two samples when cclk went 0 -> 1, and the CNET latched
    // the pin values seen at the earlier sample.
    bit   want_crc = 1'b0;
    bit   hold_init_low = 1'b0;
    int   need_bytes = 16;
    int   nbytes = 0;
    int   init_dly = 0;
    bit   crc_hit = 1'b0;
    int   cs_low_cnt = 0;
    int   done_cnt = 0;
    logic prev_cclk = 1'b0;
    logic prev_cs_b = 1'b1;
    logic prev_rdwr_b = 1'b1;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        logic [31:0] expv;
        if (!rp_prog_b) begin
            rp_init_b = 1'b0;
            rp_done   = 1'b0;
            nbytes    = 0;
            init_dly  = 6;
            crc_hit   = 1'b0;
        end else begin
            if (init_dly > 0) init_dly--;
            else if (!hold_init_low && !crc_hit) rp_init_b = 1'b1;
            if (rp_cclk && !prev_cclk && !prev_cs_b && !prev_rdwr_b) begin
                expv = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
                check("cnet_capture", 32'(prev_data), expv);
                nbytes++;
                if (want_crc) begin
                    crc_hit   = 1'b1;
                    rp_init_b = 1'b0;
                end
                if (nbytes >= need_bytes) rp_done = 1'b1;
            end
        end
        if (!rp_cs_b) cs_low_cnt++;
        if (done) done_cnt++;
        prev_cclk   = rp_cclk;
        prev_cs_b   = rp_cs_b;
        prev_rdwr_b = rp_rdwr_b;
        prev_data   = rp_data;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers n bytes (value = index), raising vld on one cycle in every
    // 'period'. Stops after the last byte is accepted or when the DUT drops
    // out of busy after having accepted something.
    task automatic send_stream(input int n, input int last_idx, input int period,
                               input bit poke_start, output int acc);
        int cyc;
        bit poked;
        cyc   = 0;
        poked = 1'b0;
        acc   = 0;
        while (acc < n && cyc < 3000) begin
            @(negedge clk);
            prog_data     = 8'(acc);
            prog_last     = (acc == last_idx);
            prog_data_vld = (cyc % period == 0);
            start         = poke_start && !poked && acc == 3 && busy;
            if (start) poked = 1'b1;
            if (prog_data_vld && prog_data_rdy) begin
                exp_q.push_back(prog_data);
                acc++;
                if (acc - 1 == last_idx) break;
            end else if (acc > 0 && !busy) begin
                break;
            end
            cyc++;
        end
        check("stream_in_time", 32'(cyc < 3000), 32'd1);
        @(negedge clk);
        prog_data_vld = 1'b0;
        prog_last     = 1'b0;
        start         = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int cyc;
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int cnt;
        int g;
        int cs_base;
        int done_base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_prog_b", 32'(rp_prog_b), 32'd1);
        check("rst_cs_b", 32'(rp_cs_b), 32'd1);
        check("rst_rdwr_b", 32'(rp_rdwr_b), 32'd1);
        check("rst_data", 32'(rp_data), 32'd0);
        check("rst_cclk", 32'(rp_cclk), 32'd0);
        check("rst_status", {26'd0, prog_data_rdy, busy, done, error, err_code}, 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Normal programming: 16 bytes, vld held high
        cs_base   = cs_low_cnt;
        done_base = done_cnt;
        pulse_start();
        check("norm_prog_b_low", 32'(rp_prog_b), 32'd0);
        check("norm_rdwr_b_low", 32'(rp_rdwr_b), 32'd0);
        check("norm_busy", 32'(busy), 32'd1);
        cnt = 1;
        g = 0;
        while (g < 200) begin
            @(negedge clk);
            g++;
            if (rp_prog_b) break;
            cnt++;
        end
        check("norm_prog_b_width", 32'(cnt), 32'd32);
        send_stream(16, 15, 1, 1'b0, acc);
        wait_idle("norm_idle", 200);
        check("norm_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("norm_done_clear", 32'(done), 32'd0);
        check("norm_byte_cnt", 32'(byte_cnt), 32'd16);
        check("norm_error", {29'd0, error, err_code}, 32'd0);
        check("norm_cnet_done", 32'(rp_done), 32'd1);
        check("norm_cnet_bytes", 32'(nbytes), 32'd16);
        check("norm_cs_low_clks", 32'(cs_low_cnt - cs_base), 32'd32);
        check("norm_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check("norm_exp_empty", 32'(exp_q.size()), 32'd0);
        check("norm_rdwr_b_idle", 32'(rp_rdwr_b), 32'd1);

        // CRC error after the first byte
        want_crc = 1'b1;
        pulse_start();
        send_stream(16, 15, 5, 1'b0, acc);
        @(negedge clk);
        check("crc_error", 32'(error), 32'd1);
        check("crc_code", 32'(err_code), 32'd2);
        check("crc_byte_cnt", 32'(byte_cnt), 32'd1);
        check("crc_busy", 32'(busy), 32'd0);
        check("crc_cs_b", 32'(rp_cs_b), 32'd1);
        check("crc_rdwr_b", 32'(rp_rdwr_b), 32'd1);
        check("crc_accepted", 32'(acc), 32'd1);
        want_crc = 1'b0;
        repeat (4) @(negedge clk);

        // Init timeout: INIT_B never rises
        hold_init_low = 1'b1;
        cs_base = cs_low_cnt;
        pulse_start();
        check("it_error_cleared", {29'd0, error, err_code}, 32'd0);
        g = 0;
        while (!rp_prog_b && g < 200) begin
            @(negedge clk);
            g++;
        end
        cnt = 0;
        while (!error && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check("it_wait_cycles", 32'(cnt), 32'd4096);
        check("it_code", 32'(err_code), 32'd1);
        check("it_busy", 32'(busy), 32'd0);
        check("it_byte_cnt", 32'(byte_cnt), 32'd0);
        @(negedge clk);
        check("it_cs_activity", 32'(cs_low_cnt - cs_base), 32'd0);
        hold_init_low = 1'b0;
        repeat (4) @(negedge clk);

        // Done timeout: last flagged on byte 8, CNET needs 16
        done_base = done_cnt;
        pulse_start();
        send_stream(8, 7, 1, 1'b0, acc);
        cnt = 0;
        while (!error && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("dt_wait_cycles", 32'(cnt), 32'd1024);
        check("dt_code", 32'(err_code), 32'd3);
        check("dt_byte_cnt", 32'(byte_cnt), 32'd8);
        check("dt_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("dt_no_done", 32'(done_cnt - done_base), 32'd0);
        check("dt_exp_empty", 32'(exp_q.size()), 32'd0);

        // Throttled source with a stray start during LOAD
        cs_base   = cs_low_cnt;
        done_base = done_cnt;
        pulse_start();
        check("thr_error_cleared", 32'(error), 32'd0);
        send_stream(16, 15, 5, 1'b1, acc);
        wait_idle("thr_idle", 200);
        check("thr_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("thr_byte_cnt", 32'(byte_cnt), 32'd16);
        check("thr_error", {29'd0, error, err_code}, 32'd0);
        check("thr_cnet_bytes", 32'(nbytes), 32'd16);
        check("thr_cs_low_clks", 32'(cs_low_cnt - cs_base), 32'd32);
        check("thr_done_cnt", 32'(done_cnt - done_base), 32'd1);
        check("thr_exp_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of LOAD
        pulse_start();
        send_stream(4, -1, 1, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_prog_b", 32'(rp_prog_b), 32'd1);
        check("mid_cs_b", 32'(rp_cs_b), 32'd1);
        check("mid_rdwr_b", 32'(rp_rdwr_b), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_byte_cnt", 32'(byte_cnt), 32'd0);
        check("mid_rdy", 32'(prog_data_rdy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
